// File: rtl/datapath_pkg.sv
// Shared types for the matrix load/store responder: request record, FSM states, ls encodings.
package datapath_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        MAT_STORE = 1'b0,
        MAT_LOAD  = 1'b1
    } matrix_mem_t;

    typedef enum logic [2:0] {
        MLS_IDLE,
        MLS_LD_REQ,
        MLS_LD_WAIT,
        MLS_ST_RD,
        MLS_ST_REQ,
        MLS_DONE
    } mls_state_e;

    typedef struct packed {
        matrix_mem_t mem_type;
        logic [4:0]  rd;
        word_t       base;
        word_t       stride;
    } mls_req_t;

    localparam logic [1:0] MLS_LS_LOAD  = 2'b10;
    localparam logic [1:0] MLS_LS_STORE = 2'b01;

    // Row-0 address: base register plus the sign-extended 11-bit immediate.
    function automatic word_t mls_base(input word_t addr, input logic [10:0] imm);
        return addr + {{(WORD_W-11){imm[10]}}, imm};
    endfunction

endpackage

// File: rtl/mls_req_fifo.sv
// Request FIFO for the matrix load/store responder; pointers carry an extra wrap bit.
module mls_req_fifo
    import datapath_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     push,
    input  mls_req_t wdata,
    input  logic     pop,
    output mls_req_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    mls_req_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/matrix_ls_responder.sv
// Scratchpad responder expanding matrix load/store requests into strided row transfers.
// Define MATRIX_LS_PERF_EN to add saturating performance counters.
//
// state    | meaning
// IDLE     | waiting for a queued request
// LD_REQ   | load: row read request on the memory port, held until grant
// LD_WAIT  | load: waiting for read data, written straight into the matrix RF
// ST_RD    | store: reading the current row from the matrix RF
// ST_REQ   | store: row write request on the memory port, held until grant
// DONE     | one-cycle completion pulse
module matrix_ls_responder
    import datapath_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int ROW_W      = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_ls,
    input  logic [4:0]               req_rd,
    input  logic [10:0]              req_imm,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [ADDR_W-1:0]        req_stride,
    output logic                     mem_req,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [ROW_W-1:0]         mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [ROW_W-1:0]         mem_rdata,
    output logic                     mrf_wen,
    output logic [4:0]               mrf_waddr,
    output logic [$clog2(ROWS)-1:0]  mrf_wrow,
    output logic [ROW_W-1:0]         mrf_wdata,
    output logic                     mrf_ren,
    output logic [4:0]               mrf_raddr,
    output logic [$clog2(ROWS)-1:0]  mrf_rrow,
    input  logic [ROW_W-1:0]         mrf_rdata,
    output logic                     done,
    output logic [4:0]               done_rd,
    output logic                     done_load,
`ifdef MATRIX_LS_PERF_EN
    output logic [31:0]              perf_busy_cycles,
    output logic [31:0]              perf_loads,
    output logic [31:0]              perf_stores,
    output logic [31:0]              perf_stall_cycles,
`endif
    output logic                     err
);

    localparam int RW = $clog2(ROWS);

    mls_state_e       state;
    mls_req_t         fifo_wdata;
    mls_req_t         fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             accept;
    logic             ls_legal;
    logic             ready_en;
    logic [4:0]       cur_rd;
    logic             cur_load;
    word_t            cur_stride;
    word_t            row_addr;
    word_t            next_addr;
    logic [RW-1:0]    row;
    logic             last_row;
    logic [ROW_W-1:0] row_q;
    logic             st_first;

    assign ls_legal  = (req_ls == MLS_LS_LOAD) || (req_ls == MLS_LS_STORE);
    assign accept    = req_valid && req_ready;
    assign fifo_push = accept && ls_legal;
    assign fifo_pop  = (state == MLS_IDLE) && !fifo_empty;
    // ready_en keeps req_ready low while reset is applied and for the first cycle after
    assign req_ready = ready_en && !fifo_full;

    always_comb begin
        fifo_wdata          = '0;
        fifo_wdata.mem_type = (req_ls == MLS_LS_LOAD) ? MAT_LOAD : MAT_STORE;
        fifo_wdata.rd       = req_rd;
        fifo_wdata.base     = mls_base(req_addr, req_imm);
        fifo_wdata.stride   = req_stride;
    end

    mls_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign next_addr = row_addr + cur_stride;
    assign last_row  = (row == RW'(ROWS-1));

    // Load data goes straight to the RF in the rvalid cycle; store data comes from
    // the RF read port in the first ST_REQ cycle and from row_q while stalled.
    assign mrf_wen   = (state == MLS_LD_WAIT) && mem_rvalid;
    assign mrf_waddr = mrf_wen ? cur_rd : '0;
    assign mrf_wrow  = mrf_wen ? row : '0;
    assign mrf_wdata = mrf_wen ? mem_rdata : '0;
    assign mem_wdata = (state == MLS_ST_REQ) ? (st_first ? mrf_rdata : row_q) : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= MLS_IDLE;
            ready_en   <= 1'b0;
            cur_rd     <= '0;
            cur_load   <= 1'b0;
            cur_stride <= '0;
            row_addr   <= '0;
            row        <= '0;
            row_q      <= '0;
            st_first   <= 1'b0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mrf_ren    <= 1'b0;
            mrf_raddr  <= '0;
            mrf_rrow   <= '0;
            done       <= 1'b0;
            done_rd    <= '0;
            done_load  <= 1'b0;
            err        <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            err       <= accept && !ls_legal;
            done      <= 1'b0;
            done_rd   <= '0;
            done_load <= 1'b0;
            mrf_ren   <= 1'b0;
            case (state)
                MLS_IDLE: begin
                    if (!fifo_empty) begin
                        cur_rd     <= fifo_rdata.rd;
                        cur_load   <= (fifo_rdata.mem_type == MAT_LOAD);
                        cur_stride <= fifo_rdata.stride;
                        row_addr   <= fifo_rdata.base;
                        row        <= '0;
                        if (fifo_rdata.mem_type == MAT_LOAD) begin
                            state    <= MLS_LD_REQ;
                            mem_req  <= 1'b1;
                            mem_wen  <= 1'b0;
                            mem_addr <= fifo_rdata.base;
                        end else begin
                            state     <= MLS_ST_RD;
                            mrf_ren   <= 1'b1;
                            mrf_raddr <= fifo_rdata.rd;
                            mrf_rrow  <= '0;
                        end
                    end
                end
                MLS_LD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= MLS_LD_WAIT;
                    end
                end
                MLS_LD_WAIT: begin
                    if (mem_rvalid) begin
                        if (last_row) begin
                            state     <= MLS_DONE;
                            done      <= 1'b1;
                            done_rd   <= cur_rd;
                            done_load <= 1'b1;
                        end else begin
                            row      <= row + RW'(1);
                            row_addr <= next_addr;
                            mem_addr <= next_addr;
                            mem_req  <= 1'b1;
                            state    <= MLS_LD_REQ;
                        end
                    end
                end
                MLS_ST_RD: begin
                    state    <= MLS_ST_REQ;
                    st_first <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_wen  <= 1'b1;
                    mem_addr <= row_addr;
                end
                MLS_ST_REQ: begin
                    st_first <= 1'b0;
                    if (st_first)
                        row_q <= mrf_rdata;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        if (last_row) begin
                            state     <= MLS_DONE;
                            done      <= 1'b1;
                            done_rd   <= cur_rd;
                            done_load <= 1'b0;
                        end else begin
                            row       <= row + RW'(1);
                            row_addr  <= next_addr;
                            mrf_ren   <= 1'b1;
                            mrf_raddr <= cur_rd;
                            mrf_rrow  <= row + RW'(1);
                            state     <= MLS_ST_RD;
                        end
                    end
                end
                MLS_DONE: state <= MLS_IDLE;
                default:  state <= MLS_IDLE;
            endcase
        end
    end

`ifdef MATRIX_LS_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_busy_cycles  <= '0;
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_busy_cycles  <= sat_inc(perf_busy_cycles, state != MLS_IDLE);
            perf_loads        <= sat_inc(perf_loads, (state == MLS_DONE) && cur_load);
            perf_stores       <= sat_inc(perf_stores, (state == MLS_DONE) && !cur_load);
            perf_stall_cycles <= sat_inc(perf_stall_cycles, mem_req && !mem_gnt);
        end
    end
`endif

endmodule

// File: tb/tb_matrix_ls_responder.sv
// Scoreboard bench for matrix_ls_responder: stimulus pushes expected transfers, a monitor pops them.
module tb_matrix_ls_responder;

    localparam int ROWS = 4;
    localparam int ROW_W = 64;
    localparam int FIFO_DEPTH = 2;
    localparam int ADDR_W = 32;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_ls = '0;
    logic [4:0]        req_rd = '0;
    logic [10:0]       req_imm = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_stride = '0;
    logic              mem_req;
    logic              mem_wen;
    logic [31:0]       mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [63:0]       mem_rdata = '0;
    logic              mrf_wen;
    logic [4:0]        mrf_waddr;
    logic [1:0]        mrf_wrow;
    logic [63:0]       mrf_wdata;
    logic              mrf_ren;
    logic [4:0]        mrf_raddr;
    logic [1:0]        mrf_rrow;
    logic [63:0]       mrf_rdata = '0;
    logic              done;
    logic [4:0]        done_rd;
    logic              done_load;
    logic              err;
`ifdef MATRIX_LS_PERF_EN
    logic [31:0]       perf_busy_cycles;
    logic [31:0]       perf_loads;
    logic [31:0]       perf_stores;
    logic [31:0]       perf_stall_cycles;
`endif

    always #5 CLK = ~CLK;

    matrix_ls_responder #(
        .ROWS(ROWS), .ROW_W(ROW_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_ls(req_ls), .req_rd(req_rd),
        .req_imm(req_imm), .req_addr(req_addr), .req_stride(req_stride),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mrf_wen(mrf_wen), .mrf_waddr(mrf_waddr), .mrf_wrow(mrf_wrow), .mrf_wdata(mrf_wdata),
        .mrf_ren(mrf_ren), .mrf_raddr(mrf_raddr), .mrf_rrow(mrf_rrow), .mrf_rdata(mrf_rdata),
        .done(done), .done_rd(done_rd), .done_load(done_load),
`ifdef MATRIX_LS_PERF_EN
        .perf_busy_cycles(perf_busy_cycles), .perf_loads(perf_loads),
        .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles),
`endif
        .err(err)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  row;
        logic [63:0] data;
    } mrf_exp_t;

    mem_exp_t    mem_q[$];
    mrf_exp_t    mrf_q[$];
    logic [5:0]  done_q[$];
    logic        err_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int timeouts = 0;
    logic rst_chk = 1'b0;
    logic ready_chk = 1'b0;
    logic end_flag = 1'b0;

    // responder knobs
    int gnt_cnt = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int rv_extra = 0;
    int rv_cnt = 0;
    logic [31:0] g_addr = '0;
    logic        g_wen = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        ren_d = 1'b0;
    logic [4:0]  raddr_d = '0;
    logic [1:0]  rrow_d = '0;

    function automatic logic [63:0] row_data(input logic [31:0] a);
        return {~a, a};
    endfunction

    function automatic logic [63:0] rf_val(input logic [4:0] rd, input logic [1:0] r);
        return {16'hC0DE, 11'd0, rd, 16'hBEEF, 14'd0, r};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got an event, expected none", name);
    endfunction

    // Memory slave and matrix RF read port, driven 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        mrf_rdata = ren_d ? rf_val(raddr_d, rrow_d) : 64'hDEAD_DEAD_DEAD_DEAD;
        ren_d = mrf_ren;
        raddr_d = mrf_raddr;
        rrow_d = mrf_rrow;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        if (!nRST) begin
            mem_gnt = 1'b0;
            rv_cnt = 0;
        end else begin
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = row_data(pend_addr);
                end
            end
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                gnt_cnt++;
                if (!g_wen) begin
                    pend_addr = g_addr;
                    if (rv_extra == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = row_data(g_addr);
                    end else begin
                        rv_cnt = rv_extra;
                    end
                end
            end else if (mem_req) begin
                if (gnt_cnt == stall_idx && stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_gnt = 1'b1;
                    g_addr = mem_addr;
                    g_wen = mem_wen;
                end
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge.
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic        prev_wen = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [63:0] prev_wdata = '0;

    always @(negedge CLK) begin
        mem_exp_t m;
        mrf_exp_t f;
        logic [5:0] d;
        if (rst_chk) begin
            chk("rst_mem_ctl", 64'({mem_req, mem_wen, mem_addr}), 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
            chk("rst_mrf_ctl", 64'({mrf_wen, mrf_waddr, mrf_wrow, mrf_ren, mrf_raddr, mrf_rrow}), 64'd0);
            chk("rst_mrf_wdata", mrf_wdata, 64'd0);
            chk("rst_done", 64'({done, done_rd, done_load}), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end else if (nRST) begin
            if (ready_chk) begin
                chk("ready_when_full", 64'(req_ready), 64'd0);
                ready_chk = 1'b0;
            end
            if (mem_req && prev_req && !prev_gnt) begin
                chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
                chk("hold_wen", 64'(mem_wen), 64'(prev_wen));
                chk("hold_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req && mem_gnt) begin
                if (mem_q.size() == 0) unexpected("mem_transfer");
                else begin
                    m = mem_q.pop_front();
                    chk("mem_wen", 64'(mem_wen), 64'(m.wen));
                    chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                    if (m.wen) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (mrf_wen) begin
                if (mrf_q.size() == 0) unexpected("mrf_write");
                else begin
                    f = mrf_q.pop_front();
                    chk("mrf_waddr", 64'(mrf_waddr), 64'(f.rd));
                    chk("mrf_wrow", 64'(mrf_wrow), 64'(f.row));
                    chk("mrf_wdata", mrf_wdata, f.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    d = done_q.pop_front();
                    chk("done_rd_load", 64'({done_rd, done_load}), 64'(d));
                end
            end
            if (err) begin
                if (err_q.size() == 0) unexpected("err");
                else void'(err_q.pop_front());
            end
            if (end_flag) begin
                chk("left_mem_q", 64'(mem_q.size()), 64'd0);
                chk("left_mrf_q", 64'(mrf_q.size()), 64'd0);
                chk("left_done_q", 64'(done_q.size()), 64'd0);
                chk("left_err_q", 64'(err_q.size()), 64'd0);
                chk("timeouts", 64'(timeouts), 64'd0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $finish;
            end
        end
        if (!nRST) begin
            prev_req = 1'b0;
            prev_gnt = 1'b0;
        end else begin
            prev_req = mem_req;
            prev_gnt = mem_gnt;
            prev_wen = mem_wen;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic issue(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [10:0] imm, input logic [31:0] stride);
        int t;
        logic [31:0] base;
        mem_exp_t m;
        mrf_exp_t f;
        t = 0;
        @(negedge CLK);
        req_valid = 1'b1;
        req_ls = ls;
        req_rd = rd;
        req_addr = addr;
        req_imm = imm;
        req_stride = stride;
        while (!req_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) begin
            timeouts++;
            $display("FAIL issue_timeout: got req_ready=0, expected 1 within 200 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
        if (ls == 2'b10 || ls == 2'b01) begin
            base = addr + {{21{imm[10]}}, imm};
            for (int r = 0; r < ROWS; r++) begin
                m.wen = (ls == 2'b01);
                m.addr = base + 32'(r) * stride;
                m.wdata = m.wen ? rf_val(rd, 2'(r)) : 64'd0;
                mem_q.push_back(m);
                if (ls == 2'b10) begin
                    f.rd = rd;
                    f.row = 2'(r);
                    f.data = row_data(m.addr);
                    mrf_q.push_back(f);
                end
            end
            done_q.push_back({rd, ls == 2'b10});
        end else begin
            err_q.push_back(1'b1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((mem_q.size() + mrf_q.size() + done_q.size() + err_q.size()) != 0 && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 1000) begin
            timeouts++;
            $display("FAIL drain_timeout: got pending expectations, expected all consumed");
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int t;
        nRST = 1'b0;
        rst_chk = 1'b1;
        repeat (3) @(negedge CLK);
        rst_chk = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // load with negative immediate
        issue(2'b10, 5'd3, 32'h0000_1000, 11'h7F0, 32'h40);
        wait_drain();

        // store with a 3-cycle grant stall on row 1
        stall_idx = gnt_cnt + 1;
        stall_left = 3;
        issue(2'b01, 5'd7, 32'h0000_2000, 11'h000, 32'h8);
        wait_drain();

        // address wrap
        issue(2'b10, 5'd10, 32'hFFFF_FFF0, 11'h000, 32'h10);
        wait_drain();

        // FIFO fill while the first request stalls; third uses stride 0 and positive imm
        stall_idx = gnt_cnt;
        stall_left = 10;
        issue(2'b10, 5'd1, 32'h0000_4000, 11'h000, 32'h4);
        issue(2'b01, 5'd2, 32'h0000_5000, 11'h004, 32'h100);
        issue(2'b10, 5'd4, 32'h0000_6000, 11'h100, 32'h0);
        ready_chk = 1'b1;
        wait_drain();

        // illegal ls encodings
        issue(2'b11, 5'd12, 32'h0000_7000, 11'h000, 32'h4);
        issue(2'b00, 5'd13, 32'h0000_7100, 11'h000, 32'h4);
        wait_drain();

        // reset during LD_WAIT
        rv_extra = 6;
        issue(2'b10, 5'd9, 32'h0000_3000, 11'h000, 32'h20);
        t = 0;
        while (!(mem_req && mem_gnt) && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) begin
            timeouts++;
            $display("FAIL grant_timeout: got no grant, expected one within 100 cycles");
        end
        @(negedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        mem_q.delete();
        mrf_q.delete();
        done_q.delete();
        rv_extra = 0;
        rst_chk = 1'b1;
        repeat (2) @(negedge CLK);
        rst_chk = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        repeat (2) @(negedge CLK);
        issue(2'b10, 5'd11, 32'h0000_8000, 11'h010, 32'h80);
        wait_drain();

        end_flag = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/matrix_ls_responder.md
Name: matrix_ls_responder

Overview:
- Scratchpad-side responder for matrix load/store requests issued by the matrix LD/ST functional unit.
- Each request is buffered in a small FIFO, then expanded into ROWS strided memory row transfers.
- A load moves memory rows into the matrix register file; a store moves matrix register file rows out to memory.
- Completion is reported back to the FU/scoreboard with a one-cycle done pulse.

Parameters:
- ROWS, 4, matrix rows moved per request (power of 2).
- ROW_W, 64, bits per row (4 x fp16).
- FIFO_DEPTH, 2, request FIFO entries (power of 2, >=2).
- ADDR_W, 32, memory address width (word_t width).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_ls  in  2  {load, store}; 2'b10 = load, 2'b01 = store.
- req_rd  in  5  matrix register number.
- req_imm  in  11  signed row-0 offset.
- req_addr  in  ADDR_W  base address.
- req_stride  in  ADDR_W  byte distance between rows.
- mem_req  out  1  memory request valid.
- mem_wen  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  row address.
- mem_wdata  out  ROW_W  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  ROW_W  read data.
- mrf_wen  out  1  matrix RF row write.
- mrf_waddr  out  5  matrix register.
- mrf_wrow  out  $clog2(ROWS)  row index.
- mrf_wdata  out  ROW_W  row data.
- mrf_ren  out  1  matrix RF row read.
- mrf_raddr  out  5  matrix register.
- mrf_rrow  out  $clog2(ROWS)  row index.
- mrf_rdata  in  ROW_W  read data, valid the cycle after mrf_ren.
- done  out  1  one-cycle completion pulse.
- done_rd  out  5  register of the completed request.
- done_load  out  1  completed request was a load.
- err  out  1  one-cycle pulse: illegal req_ls dropped.

Behaviour:
- Reset: every output is 0, the FIFO is empty, and the FSM is in IDLE. nRST asserted mid-transfer abandons the transfer with no done pulse.
- Request handshake: a request is accepted when req_valid && req_ready.
- Illegal req_ls (2'b00 or 2'b11): the request is accepted but not enqueued, and err pulses the following cycle.
- req_ready is 0 when the FIFO is full. An accept and a pop in the same cycle while full is not permitted (ready is already low).
- Address generation:
  - base = req_addr + sign_extend(req_imm), computed at enqueue.
  - row r address = base + r*req_stride, computed with an incremental adder, wrapping modulo 2^ADDR_W.
  - stride 0 is legal: every row uses the same address.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_RD, ST_REQ, DONE.
- IDLE: if the FIFO is non-empty, pop it, set row = 0, and go to LD_REQ (load) or ST_RD (store).
- LD_REQ:
  - Drives mem_req = 1, mem_wen = 0, mem_addr = row address.
  - Holds these values stable until mem_gnt, then goes to LD_WAIT.
- LD_WAIT:
  - On mem_rvalid, in the same cycle: mrf_wen = 1 with waddr = rd, wrow = row, wdata = mem_rdata.
  - Then if row == ROWS-1 go to DONE, else row++ and go to LD_REQ.
  - At most one memory read is outstanding.
  - mem_rvalid and mem_gnt arriving in the same cycle as the request is not supported; rvalid comes at least 1 cycle after gnt.
- ST_RD: mrf_ren = 1, raddr = rd, rrow = row; go to ST_REQ the next cycle.
- ST_REQ:
  - Captures mrf_rdata into a row register on entry.
  - Drives mem_req = 1, mem_wen = 1, mem_wdata = row register, held until mem_gnt.
  - On gnt: if last row go to DONE, else row++ and go to ST_RD.
- DONE: done = 1 with done_rd and done_load for one cycle, then IDLE. Back-to-back requests therefore have a 1-cycle IDLE bubble.
- Minimum latency from pop to done:
  - Load: ROWS*(2 + gnt wait + rvalid wait) + 1.
  - Store: ROWS*2 + 1 with zero gnt wait.

Optional Feature:
- Macro: MATRIX_LS_PERF_EN.
- Defined: adds outputs perf_busy_cycles (32), perf_loads (32), perf_stores (32), and perf_stall_cycles (32).
  - perf_busy_cycles counts every cycle the FSM is not in IDLE.
  - perf_loads and perf_stores increment in DONE.
  - perf_stall_cycles counts cycles with mem_req = 1 && !mem_gnt.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- datapath_pkg gains:
  - mls_state_e (the six FSM states).
  - mls_req_t {matrix_mem_t mem_type, logic [4:0] rd, word_t base, word_t stride}.
  - Constants MLS_LS_LOAD = 2'b10 and MLS_LS_STORE = 2'b01.
- Sub-module: mls_req_fifo, a parameterised synchronous FIFO of mls_req_t with full/empty flags and wrap-around pointers (extra MSB).

Test Plan:
- Load, rd=3, addr=0x1000, imm=-16, stride=0x40, gnt same cycle, rvalid +1: mem_addr sequence 0xFF0, 0x1030, 0x1070, 0x10B0; four mrf writes to rows 0..3 of reg 3; then done=1, done_rd=3, done_load=1.
- Store, rd=7, addr=0x2000, stride=8, gnt stalled 3 cycles on row 1: mem_addr/mem_wdata held stable during the stall; wdata equals the RF rows; done_load=0.
- Address wrap: addr=0xFFFFFFF0, stride=0x10, imm=0: row addresses 0xFFFFFFF0, 0x0, 0x10, 0x20.
- FIFO: three back-to-back requests while the first stalls: req_ready drops after 2 queued; all three complete in order with correct done_rd values.
- req_ls=2'b11 then 2'b00: err pulses twice, no memory or RF activity, no done.
- nRST pulsed low during LD_WAIT: all outputs 0, FIFO empty; a new load afterwards completes normally.
